// File: rtl/bcd_scan_counter.sv
// Four-digit cascaded BCD up/down counter with a time-multiplexed digit scan for a 7-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero digits during their scan slots.
module bcd_scan_counter #(
    parameter int CNT_DIV  = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        En,
    input  logic        Up,
    input  logic        Clr,
    input  logic        Load,
    input  logic [15:0] Load_val,
    output logic [15:0] Count,
    output logic        Carry,
    output logic [3:0]  BCD_num,
    output logic [3:0]  Dis_sel
);
    localparam int CW = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_pre_q, cnt_pre_d;
    logic [SW-1:0] scan_pre_q, scan_pre_d;
    logic [15:0]   count_q, count_d;
    logic          carry_q, carry_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [3:0]    sel_q, sel_d;

    logic          tick;
    logic [4:0]    chain;
    logic [15:0]   step_val;
    logic [15:0]   load_clean;
    logic          blank;

    assign tick     = En && (cnt_pre_q == CNT_MAX);
    assign chain[0] = 1'b1;

    // Ripple carry/borrow: a digit moves only when every lower digit sits at its rollover value.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] dig;
            logic [3:0] ld;
            logic       at_edge;
            assign dig     = count_q[gi*4 +: 4];
            assign ld      = Load_val[gi*4 +: 4];
            assign at_edge = Up ? (dig == 4'd9) : (dig == 4'd0);
            assign chain[gi+1] = chain[gi] & at_edge;
            assign step_val[gi*4 +: 4] = !chain[gi] ? dig :
                                         Up ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) :
                                              ((dig == 4'd0) ? 4'd9 : dig - 4'd1);
            assign load_clean[gi*4 +: 4] = (ld > 4'd9) ? 4'd0 : ld;
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lz;
    assign lz[3] = (count_q[15:12] == 4'd0);
    assign lz[2] = (count_q[11:8]  == 4'd0) && lz[3];
    assign lz[1] = (count_q[7:4]   == 4'd0) && lz[2];
    assign lz[0] = 1'b0;
    assign blank = lz[idx_d];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        cnt_pre_d = cnt_pre_q;
        count_d   = count_q;
        carry_d   = 1'b0;
        if (!En || tick) begin
            cnt_pre_d = '0;
        end else begin
            cnt_pre_d = cnt_pre_q + 1'b1;
        end
        if (Clr) begin
            count_d   = '0;
            cnt_pre_d = '0;
        end else if (Load) begin
            count_d   = load_clean;
            cnt_pre_d = '0;
        end else if (tick) begin
            count_d = step_val;
            carry_d = chain[4];
        end
    end

    // Scan runs regardless of En/Clr/Load; outputs follow the index chosen on this edge.
    always_comb begin
        scan_pre_d = scan_pre_q + 1'b1;
        idx_d      = idx_q;
        if (scan_pre_q == SCAN_MAX) begin
            scan_pre_d = '0;
            idx_d      = idx_q + 2'd1;
        end
        bcd_d = count_q[{idx_d, 2'b00} +: 4];
        sel_d = blank ? 4'b1111 : ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_pre_q  <= '0;
            scan_pre_q <= '0;
            count_q    <= '0;
            carry_q    <= 1'b0;
            idx_q      <= 2'd0;
            bcd_q      <= 4'h0;
            sel_q      <= 4'b1110;
        end else begin
            cnt_pre_q  <= cnt_pre_d;
            scan_pre_q <= scan_pre_d;
            count_q    <= count_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            bcd_q      <= bcd_d;
            sel_q      <= sel_d;
        end
    end

    assign Count   = count_q;
    assign Carry   = carry_q;
    assign BCD_num = bcd_q;
    assign Dis_sel = sel_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with CNT_DIV=4, SCAN_DIV=2; hand-computed expectations.
// Build with LEADING_ZERO_BLANK_EN defined to exercise the blanking expectations.
module tb_bcd_scan_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        En = 1'b0, Up = 1'b0, Clr = 1'b0, Load = 1'b0;
    logic [15:0] Load_val = 16'h0000;
    logic [15:0] Count;
    logic        Carry;
    logic [3:0]  BCD_num, Dis_sel;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_scan_counter #(.CNT_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .En(En), .Up(Up), .Clr(Clr), .Load(Load),
        .Load_val(Load_val), .Count(Count), .Carry(Carry),
        .BCD_num(BCD_num), .Dis_sel(Dis_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 ns later, and verify every digit is valid BCD.
    task automatic step();
        logic ok;
        @(posedge clk);
        #1;
        ok = (Count[3:0] <= 4'd9) && (Count[7:4] <= 4'd9) &&
             (Count[11:8] <= 4'd9) && (Count[15:12] <= 4'd9);
        chk("bcd_invariant", {15'd0, ok}, 16'd1);
    endtask

    task automatic load(input logic [15:0] v);
        Load_val = v;
        Load = 1'b1;
        step();
        Load = 1'b0;
        $display("load %h -> Count=%h", v, Count);
    endtask

    // Step until the first cycle of scan slot 0 (Dis_sel just became 1110).
    task automatic sync_slot0();
        logic [3:0] prev;
        logic       found;
        prev  = Dis_sel;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (Dis_sel == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = Dis_sel;
        end
        chk("scan_sync", {15'd0, found}, 16'd1);
    endtask

    initial begin
        logic [3:0] exp_sel [4];
        logic [3:0] exp_bcd [4];

        // Reset state
        repeat (2) step();
        chk("rst_count", Count, 16'h0000);
        chk("rst_carry", {15'd0, Carry}, 16'd0);
        chk("rst_sel", {12'd0, Dis_sel}, 16'h000e);
        chk("rst_bcd", {12'd0, BCD_num}, 16'h0000);
        rst_n = 1'b1;
        step();
        $display("reset released Count=%h Dis_sel=%b", Count, Dis_sel);

        // Count up across 0998 -> 0999 -> 1000
        En = 1'b1;
        Up = 1'b1;
        load(16'h0998);
        chk("up_load", Count, 16'h0998);
        repeat (3) begin
            step();
            chk("up_hold", Count, 16'h0998);
            chk("up_carry0", {15'd0, Carry}, 16'd0);
        end
        step();
        chk("up_0999", Count, 16'h0999);
        chk("up_carry1", {15'd0, Carry}, 16'd0);
        repeat (3) step();
        step();
        chk("up_1000", Count, 16'h1000);
        chk("up_carry2", {15'd0, Carry}, 16'd0);
        $display("count up 0998 -> %h", Count);

        // Wrap up 9999 -> 0000, then down 0000 -> 9999
        load(16'h9999);
        repeat (3) step();
        step();
        chk("wrap_up", Count, 16'h0000);
        chk("wrap_up_carry", {15'd0, Carry}, 16'd1);
        Up = 1'b0;
        repeat (3) begin
            step();
            chk("carry_pulse_end", {15'd0, Carry}, 16'd0);
            chk("down_hold", Count, 16'h0000);
        end
        step();
        chk("wrap_down", Count, 16'h9999);
        chk("wrap_down_carry", {15'd0, Carry}, 16'd1);
        step();
        chk("wrap_down_carry_end", {15'd0, Carry}, 16'd0);
        chk("after_wrap_down", Count, 16'h9999);
        $display("wrap up/down done Count=%h", Count);

        // Invalid digits zeroed, Clr beats Load
        En = 1'b0;
        load(16'h12AF);
        chk("load_invalid", Count, 16'h1200);
        Load_val = 16'h5555;
        Load = 1'b1;
        Clr = 1'b1;
        step();
        Load = 1'b0;
        Clr = 1'b0;
        chk("clr_over_load", Count, 16'h0000);
        $display("clr+load -> Count=%h", Count);

        // Scan of 4321 with counting frozen
        load(16'h4321);
        sync_slot0();
        exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_bcd = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int k = 0; k < 8; k++) begin
            chk("scan_sel", {12'd0, Dis_sel}, {12'd0, exp_sel[k/2]});
            chk("scan_bcd", {12'd0, BCD_num}, {12'd0, exp_bcd[k/2]});
            step();
        end
        chk("scan_count_frozen", Count, 16'h4321);
        $display("scan 4321 done");

        // Scan of 0070: leading zeros blanked only when the feature is built in
        load(16'h0070);
        sync_slot0();
`ifdef LEADING_ZERO_BLANK_EN
        exp_sel = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
        exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
        exp_bcd = '{4'h0, 4'h7, 4'h0, 4'h0};
        for (int k = 0; k < 8; k++) begin
            chk("lz_sel", {12'd0, Dis_sel}, {12'd0, exp_sel[k/2]});
            chk("lz_bcd", {12'd0, BCD_num}, {12'd0, exp_bcd[k/2]});
            step();
        end
        $display("scan 0070 done");

        // Asynchronous reset in the middle of counting and scanning
        En = 1'b1;
        Up = 1'b1;
        load(16'h0559);
        repeat (5) step();
        chk("pre_reset_count", Count, 16'h0560);
        rst_n = 1'b0;
        #2;
        chk("arst_count", Count, 16'h0000);
        chk("arst_carry", {15'd0, Carry}, 16'd0);
        chk("arst_sel", {12'd0, Dis_sel}, 16'h000e);
        chk("arst_bcd", {12'd0, BCD_num}, 16'h0000);
        step();
        chk("arst_hold", Count, 16'h0000);
        rst_n = 1'b1;
        step();
        $display("async reset -> Count=%h Dis_sel=%b", Count, Dis_sel);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
